// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the store buffer:
//   - drain_state_e : drain FSM states (IDLE, WR, RD, RMW)
//   - sb_entry_t    : one queued store {addr, data, word}
//   - WORD_BYTES / HALF_BYTES : access sizes in bytes
//   - range_overlap : byte-range intersection test between a load and an entry
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int HALF_BYTES = 2;
    localparam int ADDR_W     = 32;
    // One extra bit so that address + size never wraps past the top of memory.
    localparam int XW         = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RMW  = 2'd3
    } drain_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              word;
    } sb_entry_t;

    // Load [a, a+L-1] intersects entry [s, s+3]; L is 4 for word, 2 for halfword.
    function automatic logic range_overlap(input logic [ADDR_W-1:0] ld_addr,
                                           input logic              ld_word,
                                           input logic [ADDR_W-1:0] st_addr);
        logic [XW-1:0] ld_lo;
        logic [XW-1:0] ld_hi;
        logic [XW-1:0] st_lo;
        logic [XW-1:0] st_hi;
        ld_lo = {1'b0, ld_addr};
        ld_hi = ld_lo + (ld_word ? XW'(WORD_BYTES - 1) : XW'(HALF_BYTES - 1));
        st_lo = {1'b0, st_addr};
        st_hi = st_lo + XW'(WORD_BYTES - 1);
        return (ld_lo <= st_hi) && (st_lo <= ld_hi);
    endfunction

endpackage

// File: rtl/store_fifo.sv
// -----------------------------------------------------------------------------
// store_fifo
// Circular buffer of DEPTH store entries with head/tail pointers and a count.
// Every slot is also presented in age order (index 0 = head = oldest) so the
// top level can compare a load against all pending stores in parallel.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_entry    enqueue request (ignored while full, even with pop)
//   pop                 dequeue head (ignored while empty)
//   full, empty         occupancy flags
//   age_entry/age_valid all slots, oldest first, with valid mask
// -----------------------------------------------------------------------------
module store_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  sb_entry_t        push_entry,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output sb_entry_t        age_entry [DEPTH],
    output logic [DEPTH-1:0] age_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   head_d;
    logic [PW-1:0]   tail_q;
    logic [PW-1:0]   tail_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == CW'(0));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        head_d  = do_pop  ? head_q + PW'(1) : head_q;
        tail_d  = do_push ? tail_q + PW'(1) : tail_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Age-ordered view of the buffer for the parallel overlap compare.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_entry[i] = mem_q[head_q + PW'(i)];
            age_valid[i] = (CW'(i) < count_q);
        end
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (do_push) begin
                mem_q[tail_q] <= push_entry;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Queues MEM-stage stores and drains them into a byte-addressed RAM one write
// at a time; loads use the RAM port directly unless they overlap a pending
// store. Halfword stores are drained as read (RD) then merged write (RMW),
// since the RAM always writes 4 bytes.
// Optional build macro: STORE_FWD_EN -- forward a load from the youngest
// overlapping entry when the addresses match exactly and the entry covers the
// load (word entry, or halfword load).
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   req_valid/write/addr/data/word/sign MEM-stage request
//   stall                               hold the request this cycle
//   ld_valid, ld_data                   zero-latency load result
//   drained                             buffer empty and drain FSM idle
//   ram_address/dataIn/write/word/sign  RAM command
//   ram_dataOut                         RAM combinational read data
// -----------------------------------------------------------------------------
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_data,
    input  logic          req_word,
    input  logic          req_sign,
    output logic          stall,
    output logic          ld_valid,
    output logic [31:0]   ld_data,
    output logic          drained,
    output logic [31:0]   ram_address,
    output logic [31:0]   ram_dataIn,
    output logic          ram_write,
    output logic          ram_word,
    output logic          ram_sign,
    input  logic [31:0]   ram_dataOut
);

`ifdef STORE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    drain_state_e     state_q;
    drain_state_e     state_d;
    logic [31:0]      merge_q;
    logic [31:0]      merge_d;

    sb_entry_t        age_entry [DEPTH];
    logic [DEPTH-1:0] age_valid;
    sb_entry_t        push_entry;
    sb_entry_t        young_ent;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]      fwd_data;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             is_load;
    logic             hit_any;
    logic             hit_i;
    logic             fwd_ok;
    logic             ld_stall;
    logic             load_grant;
    logic             fsm_grant;

    assign ld_addr    = ADDR_W'(req_addr);
    assign push_entry = '{addr: ld_addr, data: req_data, word: req_word};
    assign push       = req_valid & req_write & ~full;
    assign is_load    = req_valid & ~req_write;

    store_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .age_entry  (age_entry),
        .age_valid  (age_valid)
    );

    // Overlap against every pending entry; the last hit in age order is the youngest.
    always_comb begin
        hit_any   = 1'b0;
        hit_i     = 1'b0;
        young_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_i     = age_valid[i] & range_overlap(ld_addr, req_word, age_entry[i].addr);
            hit_any   = hit_any | hit_i;
            young_ent = hit_i ? age_entry[i] : young_ent;
        end
    end

    // Forwarding is safe only when the youngest overlapping store covers the whole load.
    assign fwd_ok   = FWD_EN & hit_any & (young_ent.addr == ld_addr) &
                      (young_ent.word | ~req_word);
    assign fwd_data = req_word ? young_ent.data
                               : {{16{req_sign & young_ent.data[15]}}, young_ent.data[15:0]};

    assign ld_stall   = is_load & hit_any & ~fwd_ok;
    assign load_grant = is_load & ~ld_stall;
    assign fsm_grant  = ~load_grant;

    assign stall    = ld_stall | (req_valid & req_write & full);
    assign ld_valid = load_grant;
    assign ld_data  = load_grant ? (fwd_ok ? fwd_data : ram_dataOut) : 32'h0;
    assign drained  = empty & (state_q == IDLE);

    // Drain FSM next state; every transition needs the RAM port this cycle.
    always_comb begin
        state_d = state_q;
        merge_d = merge_q;
        pop     = 1'b0;
        if (fsm_grant) begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_d = age_entry[0].word ? WR : RD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WR: begin
                    pop = 1'b1;
                    // Stay in WR when the entry becoming head is also a word store.
                    if (age_valid[1]) begin
                        state_d = age_entry[1].word ? WR : IDLE;
                    end else if (push) begin
                        state_d = req_word ? WR : IDLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RD: begin
                    merge_d = ram_dataOut;
                    state_d = RMW;
                end
                RMW: begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // RAM command: a granted load owns the port, otherwise the drain FSM does.
    always_comb begin
        ram_address = 32'h0;
        ram_dataIn  = 32'h0;
        ram_write   = 1'b0;
        ram_word    = 1'b0;
        ram_sign    = 1'b0;
        if (load_grant) begin
            ram_address = 32'(ld_addr);
            ram_word    = req_word;
            ram_sign    = req_sign;
        end else begin
            case (state_q)
                WR: begin
                    ram_address = 32'(age_entry[0].addr);
                    ram_dataIn  = age_entry[0].data;
                    ram_write   = 1'b1;
                    ram_word    = 1'b1;
                end
                RD: begin
                    ram_address = 32'(age_entry[0].addr);
                    ram_word    = 1'b1;
                end
                RMW: begin
                    ram_address = 32'(age_entry[0].addr);
                    ram_dataIn  = {merge_q[31:16], age_entry[0].data[15:0]};
                    ram_write   = 1'b1;
                    ram_word    = 1'b1;
                end
                default: ram_write = 1'b0;
            endcase
        end
    end

    // Drain FSM state and merge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            merge_q <= 32'h0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Scoreboard bench: a shadow memory updated in program order gives the
// expected RAM writes and load results, queued when a request is driven and
// popped when the DUT writes the RAM or returns load data.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic        req_word = 1'b0;
    logic        req_sign = 1'b0;
    logic        stall, ld_valid, drained, ram_write, ram_word, ram_sign;
    logic [31:0] ld_data, ram_address, ram_dataIn, ram_dataOut;

    logic [7:0]  mem    [0:1023];
    logic [7:0]  shadow [0:1023];
    logic        mem_clear = 1'b1;
    logic [9:0]  ra;

    logic [63:0] exp_wr_q [$];
    logic [31:0] exp_ld_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_word    (req_word),
        .req_sign    (req_sign),
        .stall       (stall),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .drained     (drained),
        .ram_address (ram_address),
        .ram_dataIn  (ram_dataIn),
        .ram_write   (ram_write),
        .ram_word    (ram_word),
        .ram_sign    (ram_sign),
        .ram_dataOut (ram_dataOut)
    );

    // Byte-addressed RAM: combinational read, posedge 4-byte write.
    assign ra = ram_address[9:0];
    always_comb begin
        if (ram_word) begin
            ram_dataOut = {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]};
        end else begin
            ram_dataOut = {{16{ram_sign & mem[ra + 10'd1][7]}}, mem[ra + 10'd1], mem[ra]};
        end
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (ram_write) begin
            mem[ra]         <= ram_dataIn[7:0];
            mem[ra + 10'd1] <= ram_dataIn[15:8];
            mem[ra + 10'd2] <= ram_dataIn[23:16];
            mem[ra + 10'd3] <= ram_dataIn[31:24];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [9:0] a, input logic word,
                                               input logic sign);
        logic [31:0] v;
        if (word) v = {shadow[a + 10'd3], shadow[a + 10'd2], shadow[a + 10'd1], shadow[a]};
        else      v = {{16{sign & shadow[a + 10'd1][7]}}, shadow[a + 10'd1], shadow[a]};
        return v;
    endfunction

    // Scoreboard consumer: RAM writes and load results.
    always @(negedge clk) begin
        logic [63:0] ew;
        logic [31:0] el;
        if (rst_n && ram_write) begin
            if (exp_wr_q.size() == 0) begin
                chk("wr_unexpected", ram_address, 32'hFFFF_FFFF);
            end else begin
                ew = exp_wr_q.pop_front();
                chk("wr_addr", ram_address, ew[63:32]);
                chk("wr_data", ram_dataIn, ew[31:0]);
            end
        end
        if (rst_n && ld_valid) begin
            if (exp_ld_q.size() == 0) begin
                chk("ld_unexpected", ld_data, 32'hFFFF_FFFF);
            end else begin
                el = exp_ld_q.pop_front();
                chk("ld_data", ld_data, el);
            end
        end
    end

    // Drive one request until accepted; expectations are queued in program order.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic word, input logic sign, output int stalls);
        logic [9:0]  a;
        logic [31:0] wdata;
        a = addr[9:0];
        if (wr) begin
            wdata = word ? data : {shadow[a + 10'd3], shadow[a + 10'd2], data[15:0]};
            exp_wr_q.push_back({addr, wdata});
            shadow[a]         = wdata[7:0];
            shadow[a + 10'd1] = wdata[15:8];
            shadow[a + 10'd2] = wdata[23:16];
            shadow[a + 10'd3] = wdata[31:24];
        end else begin
            exp_ld_q.push_back(model_load(a, word, sign));
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_data  = data;
        req_word  = word;
        req_sign  = sign;
        stalls    = 0;
        @(negedge clk);
        while (stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (stall) chk("req_timeout", 32'(stalls), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        @(negedge clk);
        while (!(drained && exp_wr_q.size() == 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drained", {31'd0, drained}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          sum;
        logic        found;
        logic [7:0]  saved [4];
        logic [31:0] a;

        for (int i = 0; i < 1024; i++) shadow[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
        chk("rst_ram_write", {31'd0, ram_write}, 32'd0);
        chk("rst_drained", {31'd0, drained}, 32'd1);
        chk("rst_ram_address", ram_address, 32'd0);
        mem_clear = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;

        // Single word store, then idle
        do_req(1'b1, 32'd200, 32'hF00FF176, 1'b1, 1'b0, st);
        wait_drained();

        // Word then halfword to the same address: read-modify-write, then load back
        do_req(1'b1, 32'd100, 32'hAABBCCDD, 1'b1, 1'b0, st);
        do_req(1'b1, 32'd100, 32'h00001234, 1'b0, 1'b0, st);
        do_req(1'b0, 32'd100, 32'h0, 1'b1, 1'b0, st);
        chk("ld100_stalled", {31'd0, (st > 0)}, 32'd1);
        wait_drained();
        chk("mem100", {mem[103], mem[102], mem[101], mem[100]}, 32'hAABB1234);

        // Partial overlap stalls; adjacent word does not
        do_req(1'b1, 32'd204, 32'h0BADF00D, 1'b1, 1'b0, st);
        wait_drained();
        do_req(1'b1, 32'd200, 32'hCAFEBABE, 1'b1, 1'b0, st);
        do_req(1'b0, 32'd202, 32'h0, 1'b1, 1'b0, st);
        chk("ld202_stalled", {31'd0, (st > 0)}, 32'd1);
        do_req(1'b1, 32'd200, 32'h13572468, 1'b1, 1'b0, st);
        do_req(1'b0, 32'd204, 32'h0, 1'b1, 1'b0, st);
        chk("ld204_stalls", 32'(st), 32'd0);
        wait_drained();

        // Fill the buffer: a halfword head slows draining so the fifth word store hits full
        do_req(1'b1, 32'd400, 32'h0000A5A5, 1'b0, 1'b0, st);
        sum = st;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 32'd404 + 32'(4 * i), 32'h10203040 + 32'(i), 1'b1, 1'b0, st);
            sum += st;
        end
        chk("fill_no_stall", 32'(sum), 32'd0);
        do_req(1'b1, 32'd420, 32'h55AA55AA, 1'b1, 1'b0, st);
        chk("full_stall_cycles", 32'(st), 32'd1);
        wait_drained();

        // Reset asserted during the RMW write cycle
        do_req(1'b1, 32'd300, 32'h55667788, 1'b1, 1'b0, st);
        wait_drained();
        for (int i = 0; i < 4; i++) saved[i] = shadow[300 + i];
        do_req(1'b1, 32'd300, 32'h0000BEEF, 1'b0, 1'b0, st);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ram_write) found = 1'b1;
        end
        chk("rmw_seen", {31'd0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_ram_write", {31'd0, ram_write}, 32'd0);
        chk("rstmid_drained", {31'd0, drained}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rstmid_mem300", {mem[303], mem[302], mem[301], mem[300]}, 32'h55667788);
        for (int i = 0; i < 4; i++) shadow[300 + i] = saved[i];
        exp_wr_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req(1'b0, 32'd300, 32'h0, 1'b1, 1'b0, st);
        chk("ld300_no_stall", 32'(st), 32'd0);

        // Signed halfword load right behind a store to the same address
        do_req(1'b1, 32'd8, 32'h0000F176, 1'b1, 1'b0, st);
        do_req(1'b0, 32'd8, 32'h0, 1'b0, 1'b1, st);
`ifdef STORE_FWD_EN
        chk("fwd_no_stall", 32'(st), 32'd0);
`else
        chk("nofwd_stalled", {31'd0, (st > 0)}, 32'd1);
`endif
        wait_drained();

        // Mixed random traffic in a small window to provoke overlaps
        for (int i = 0; i < 40; i++) begin
            a = 32'd512 + 32'(2 * $urandom_range(0, 15));
            do_req(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), st);
        end
        wait_drained();
        repeat (2) @(negedge clk);

        chk("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
        chk("ld_queue_empty", 32'(exp_ld_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
